// File: rtl/dmem_arb_pkg.sv
// Shared constants and the address window check for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned WORDS  = 64;
  localparam int unsigned PERF_W = 16;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  // Word-aligned and inside the words-deep window.
  function automatic logic addr_ok(input logic [31:0] a, input int unsigned words);
    return (a[1:0] == 2'b00) && ({2'b00, a[31:2]} < 32'(words));
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin pick; on a tie the port that was not last granted wins.
module rr_pick2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  assign gnt0_o = req0_i & (~req1_i | last_i);
  assign gnt1_o = req1_i & (~req0_i | ~last_i);

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for two masters sharing a single-port data memory; grant is same-cycle,
// read data returns one cycle later. DMEM_ARB_PERF_EN adds saturating grant/contention counters.
module dmem_arbiter #(
  parameter int          DATA_W = 32,
  parameter int unsigned WORDS  = dmem_arb_pkg::WORDS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [31:0]       a0,
  input  logic [31:0]       a1,
  input  logic [DATA_W-1:0] wd0,
  input  logic [DATA_W-1:0] wd1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [DATA_W-1:0] rd0,
  output logic [DATA_W-1:0] rd1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic              err0,
  output logic              err1,
`ifdef DMEM_ARB_PERF_EN
  output logic [15:0]       cnt_gnt0,
  output logic [15:0]       cnt_gnt1,
  output logic [15:0]       cnt_conf,
`endif
  output logic              mem_we,
  output logic [31:0]       mem_a,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);
  import dmem_arb_pkg::*;

  logic              last_q, last_d;
  logic [DATA_W-1:0] rd0_q, rd1_q;
  logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic              pick0, pick1;
  logic              ok0, ok1;

  rr_pick2 u_pick (
    .req0_i (req0),
    .req1_i (req1),
    .last_i (last_q),
    .gnt0_o (pick0),
    .gnt1_o (pick1)
  );

  // Reset must suppress grants combinationally so nothing reaches memory.
  assign gnt0 = pick0 & reset_n;
  assign gnt1 = pick1 & reset_n;

  assign ok0 = addr_ok(a0, WORDS);
  assign ok1 = addr_ok(a1, WORDS);

  assign mem_a  = gnt1 ? a1  : a0;
  assign mem_wd = gnt1 ? wd1 : wd0;
  assign mem_we = (gnt0 & we0 & ok0) | (gnt1 & we1 & ok1);

  always_comb begin
    last_d    = last_q;
    if (gnt0 | gnt1)
      last_d = gnt1 ? PORT_DBG : PORT_CPU;
    rvalid0_d = gnt0 & ~we0 & ok0;
    rvalid1_d = gnt1 & ~we1 & ok1;
    err0_d    = gnt0 & ~ok0;
    err1_d    = gnt1 & ~ok1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_q    <= PORT_DBG;
      rd0_q     <= '0;
      rd1_q     <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
    end else begin
      last_q    <= last_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      if (rvalid0_d) rd0_q <= mem_rd;
      if (rvalid1_d) rd1_q <= mem_rd;
    end
  end

  assign rd0     = rd0_q;
  assign rd1     = rd1_q;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign err0    = err0_q;
  assign err1    = err1_q;

`ifdef DMEM_ARB_PERF_EN
  logic [PERF_W-1:0] cnt_gnt0_q, cnt_gnt1_q, cnt_conf_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_gnt0_q <= '0;
      cnt_gnt1_q <= '0;
      cnt_conf_q <= '0;
    end else begin
      if (gnt0 && cnt_gnt0_q != '1)         cnt_gnt0_q <= cnt_gnt0_q + 1'b1;
      if (gnt1 && cnt_gnt1_q != '1)         cnt_gnt1_q <= cnt_gnt1_q + 1'b1;
      if (req0 && req1 && cnt_conf_q != '1) cnt_conf_q <= cnt_conf_q + 1'b1;
    end
  end

  assign cnt_gnt0 = cnt_gnt0_q;
  assign cnt_gnt1 = cnt_gnt1_q;
  assign cnt_conf = cnt_conf_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 64-word memory on the memory port.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0, req1, we0, we1;
  logic [31:0] a0, a1, wd0, wd1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [31:0] rd0, rd1;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;
`ifdef DMEM_ARB_PERF_EN
  logic [15:0] cnt_gnt0, cnt_gnt1, cnt_conf;
  logic [15:0] s_g0, s_g1, s_cf;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req0    (req0),
    .req1    (req1),
    .we0     (we0),
    .we1     (we1),
    .a0      (a0),
    .a1      (a1),
    .wd0     (wd0),
    .wd1     (wd1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .rd0     (rd0),
    .rd1     (rd1),
    .rvalid0 (rvalid0),
    .rvalid1 (rvalid1),
    .err0    (err0),
    .err1    (err1),
`ifdef DMEM_ARB_PERF_EN
    .cnt_gnt0 (cnt_gnt0),
    .cnt_gnt1 (cnt_gnt1),
    .cnt_conf (cnt_conf),
`endif
    .mem_we  (mem_we),
    .mem_a   (mem_a),
    .mem_wd  (mem_wd),
    .mem_rd  (mem_rd)
  );

  // Memory model: combinational read, write at the clock edge, preloaded on the first edge.
  logic [31:0] mem [64];
  logic        mem_init = 1'b0;
  assign mem_rd = mem[mem_a[7:2]];

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 + 32'(i);
      mem_init <= 1'b1;
    end else if (mem_we) begin
      mem[mem_a[7:2]] <= mem_wd;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic r0, input logic w0, input logic [31:0] ad0, input logic [31:0] d0,
                     input logic r1, input logic w1, input logic [31:0] ad1, input logic [31:0] d1);
    req0 = r0; we0 = w0; a0 = ad0; wd0 = d0;
    req1 = r1; we1 = w1; a1 = ad1; wd1 = d1;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Each step: drive at the falling edge, then check 1 time unit later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    next_cycle();

    // Reset held with both ports requesting; port 0 a good write.
    for (int i = 0; i < 3; i++) begin
      drv(1, 1, 32'h0, 32'h0, 1, 0, 32'h4, 32'h0);
      #1;
      chk("rst_gnt0", 32'(gnt0), 0);
      chk("rst_gnt1", 32'(gnt1), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      next_cycle();
    end
    chk("rst_rvalid0", 32'(rvalid0), 0);
    chk("rst_rvalid1", 32'(rvalid1), 0);
    chk("rst_err0", 32'(err0), 0);
    chk("rst_err1", 32'(err1), 0);
    chk("rst_rd0", rd0, 0);
    chk("rst_rd1", rd1, 0);

    // First released cycle: tie goes to port 0.
    reset_n = 1'b1;
    #1;
    chk("rel_gnt0", 32'(gnt0), 1);
    chk("rel_gnt1", 32'(gnt1), 0);
    chk("rel_mem_we", 32'(mem_we), 1);
    next_cycle();
    drv(0, 0, 0, 0, 1, 0, 32'h4, 0);
    #1;
    chk("rel2_gnt1", 32'(gnt1), 1);
    chk("rel2_mem_we", 32'(mem_we), 0);
    chk("rel2_rvalid0", 32'(rvalid0), 0);
    next_cycle();
    idle();
    #1;
    chk("rel3_rvalid1", 32'(rvalid1), 1);
    chk("rel3_rd1", rd1, 32'hA500_0001);

    // Single-port write then read of 0x10.
    next_cycle();
    drv(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
    #1;
    chk("wr_gnt0", 32'(gnt0), 1);
    chk("wr_mem_we", 32'(mem_we), 1);
    chk("wr_mem_a", mem_a, 32'h10);
    chk("wr_mem_wd", mem_wd, 32'hDEADBEEF);
    next_cycle();
    drv(1, 0, 32'h10, 0, 0, 0, 0, 0);
    #1;
    chk("rd_gnt0", 32'(gnt0), 1);
    chk("rd_mem_we", 32'(mem_we), 0);
    next_cycle();
    idle();
    #1;
    chk("rd_rvalid0", 32'(rvalid0), 1);
    chk("rd_rd0", rd0, 32'hDEADBEEF);
    chk("rd_idle_we", 32'(mem_we), 0);
    next_cycle();
    #1;
    chk("rd_rvalid0_drop", 32'(rvalid0), 0);
    chk("rd_rd0_hold", rd0, 32'hDEADBEEF);

    // Port 1 alone reads back the same word; leaves last = port 1.
    next_cycle();
    drv(0, 0, 0, 0, 1, 0, 32'h10, 0);
    #1;
    chk("p1_gnt1", 32'(gnt1), 1);
    next_cycle();
    idle();
    #1;
    chk("p1_rvalid1", 32'(rvalid1), 1);
    chk("p1_rd1", rd1, 32'hDEADBEEF);

    // Continuous contention for 6 cycles: 0,1,0,1,0,1.
`ifdef DMEM_ARB_PERF_EN
    s_g0 = cnt_gnt0; s_g1 = cnt_gnt1; s_cf = cnt_conf;
`endif
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      drv(1, 0, 32'h20, 0, 1, 0, 32'h24, 0);
      #1;
      chk($sformatf("cont%0d_gnt0", i), 32'(gnt0), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("cont%0d_gnt1", i), 32'(gnt1), (i % 2 == 1) ? 32'd1 : 32'd0);
    end
    next_cycle();
    idle();
    #1;
    chk("cont_rd1", rd1, 32'hA500_0009);
`ifdef DMEM_ARB_PERF_EN
    chk("cnt_conf", 32'(cnt_conf - s_cf), 6);
    chk("cnt_gnt0", 32'(cnt_gnt0 - s_g0), 3);
    chk("cnt_gnt1", 32'(cnt_gnt1 - s_g1), 3);
`endif

    // Cross-port read-after-write on the top word.
    next_cycle();
    drv(0, 0, 0, 0, 1, 1, 32'hFC, 32'h12345678);
    #1;
    chk("raw_gnt1", 32'(gnt1), 1);
    chk("raw_mem_we", 32'(mem_we), 1);
    next_cycle();
    drv(1, 0, 32'hFC, 0, 0, 0, 0, 0);
    #1;
    chk("raw_gnt0", 32'(gnt0), 1);
    chk("raw_mem_a", mem_a, 32'hFC);
    next_cycle();
    idle();
    #1;
    chk("raw_rvalid0", 32'(rvalid0), 1);
    chk("raw_rd0", rd0, 32'h12345678);

    // Bad addresses: out of window write, then misaligned read.
    next_cycle();
    drv(0, 0, 0, 0, 1, 1, 32'h100, 32'hCAFEF00D);
    #1;
    chk("bad1_gnt1", 32'(gnt1), 1);
    chk("bad1_mem_we", 32'(mem_we), 0);
    next_cycle();
    drv(0, 0, 0, 0, 1, 0, 32'h0A, 0);
    #1;
    chk("bad2_gnt1", 32'(gnt1), 1);
    chk("bad2_mem_we", 32'(mem_we), 0);
    chk("bad2_err1", 32'(err1), 1);
    chk("bad2_rvalid1", 32'(rvalid1), 0);
    next_cycle();
    idle();
    #1;
    chk("bad3_err1", 32'(err1), 1);
    chk("bad3_rvalid1", 32'(rvalid1), 0);
    chk("bad3_rd1", rd1, 32'hA500_0009);
    chk("bad3_err0", 32'(err0), 0);
    next_cycle();
    #1;
    chk("bad4_err1", 32'(err1), 0);
    chk("bad_mem0", mem[0], 32'h0);

    // Reset asserted the cycle after a port 0 read grant.
    next_cycle();
    drv(1, 0, 32'h10, 0, 0, 0, 0, 0);
    #1;
    chk("mid_gnt0", 32'(gnt0), 1);
    next_cycle();
    reset_n = 1'b0;
    drv(1, 0, 32'h10, 0, 0, 0, 0, 0);
    #1;
    chk("mid_rst_gnt0", 32'(gnt0), 0);
    chk("mid_rvalid0", 32'(rvalid0), 1);
    chk("mid_rd0", rd0, 32'hDEADBEEF);
    next_cycle();
    reset_n = 1'b1;
    drv(1, 0, 32'h10, 0, 1, 0, 32'h10, 0);
    #1;
    chk("mid_rvalid0_clr", 32'(rvalid0), 0);
    chk("mid_rd0_clr", rd0, 0);
    chk("mid_tie_gnt0", 32'(gnt0), 1);
    chk("mid_tie_gnt1", 32'(gnt1), 0);
    next_cycle();
    idle();
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
